mux_nto1_arb: RTL and testbench

Parametrised N-channel, W-bit registered multiplexer; successor to the combinational 4:1 mux. Each input channel has a valid/ready handshake. The block selects one channel per cycle, either by an explicit select or by round-robin arbitration, and drives a single registered valid/ready output stage. It sits between several producers and one shared consumer, such as a bus or UART TX.

---
 rtl/mux_nto1_arb.sv | 131 +++++++++++++
 tb/tb_mux_nto1_arb.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_nto1_arb.sv
// mux_nto1_arb: N-channel registered multiplexer with valid/ready handshake.
// Channel choice is an explicit select (mode_i=0) or round-robin (mode_i=1).
// One output register; a new beat can load in the cycle the old one drains.
// Optional: define MUX_LAST_LOCK_EN to hold round-robin on one channel until
// its in_last beat, so packets from different producers never interleave.
module mux_nto1_arb #(
  parameter  int N_CH   = 4,
  parameter  int DATA_W = 8,
  localparam int SEL_W  = $clog2(N_CH)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   mode_i,
  input  logic [SEL_W-1:0]       sel_i,
  input  logic [N_CH-1:0]        in_valid_i,
  input  logic [N_CH*DATA_W-1:0] in_data_i,
  input  logic [N_CH-1:0]        in_last_i,
  output logic [N_CH-1:0]        in_ready_o,
  output logic                   out_valid_o,
  output logic [DATA_W-1:0]      out_data_o,
  output logic [SEL_W-1:0]       out_ch_o,
  input  logic                   out_ready_i
);

  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [SEL_W-1:0]  out_ch_q;
  logic [SEL_W-1:0]  rr_ptr_q;
  logic [N_CH-1:0]   gnt;
  logic [SEL_W-1:0]  gnt_idx;
  logic              accept;
  logic              xfer;
  logic [SEL_W-1:0]  rr_next;

`ifdef MUX_LAST_LOCK_EN
  logic              lock_q;
  logic [SEL_W-1:0]  lock_ch_q;
`else
  logic              unused_last;
  assign unused_last = ^in_last_i;
`endif

  // Grant: one-hot (or zero) pick of the channel allowed to transfer.
  always_comb begin
    int idx;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    if (!mode_i) begin
      // out-of-range sel matches no channel, so nothing is granted
      for (int i = 0; i < N_CH; i++) begin
        if (sel_i == SEL_W'(i) && in_valid_i[i]) begin
          gnt[i]  = 1'b1;
          gnt_idx = SEL_W'(i);
        end
      end
`ifdef MUX_LAST_LOCK_EN
    end else if (lock_q) begin
      if (in_valid_i[lock_ch_q]) begin
        gnt[lock_ch_q] = 1'b1;
        gnt_idx        = lock_ch_q;
      end
`endif
    end else begin
      for (int off = 0; off < N_CH; off++) begin
        idx = int'(rr_ptr_q) + off;
        if (idx >= N_CH) idx = idx - N_CH;
        if (!found && in_valid_i[idx]) begin
          found        = 1'b1;
          gnt[idx]     = 1'b1;
          gnt_idx      = SEL_W'(idx);
        end
      end
    end
  end

  assign accept     = !out_valid_q || out_ready_i;
  // rst_ni gate keeps ready low while the async reset is held
  assign in_ready_o = gnt & {N_CH{accept && rst_ni}};
  assign xfer       = |(in_valid_i & in_ready_o);
  assign rr_next    = (gnt_idx == SEL_W'(N_CH-1)) ? '0 : gnt_idx + 1'b1;

  // Output register: load on input transfer, clear when drained.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= in_data_i[gnt_idx*DATA_W +: DATA_W];
      out_ch_q    <= gnt_idx;
    end else if (out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef MUX_LAST_LOCK_EN
  // Arbiter state: lock on a non-last beat, release and advance on the last.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q  <= '0;
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
    end else if (!mode_i) begin
      lock_q <= 1'b0;
    end else if (xfer) begin
      if (in_last_i[gnt_idx]) begin
        lock_q   <= 1'b0;
        rr_ptr_q <= rr_next;
      end else begin
        lock_q    <= 1'b1;
        lock_ch_q <= gnt_idx;
      end
    end
  end
`else
  // Round-robin pointer: moves past the winner on each arbitrated transfer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)            rr_ptr_q <= '0;
    else if (mode_i && xfer) rr_ptr_q <= rr_next;
  end
`endif

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_ch_o    = out_ch_q;

endmodule

// File: tb/tb_mux_nto1_arb.sv
// Scoreboard bench for mux_nto1_arb (N_CH=4 main instance, N_CH=6 for sel range).
module tb_mux_nto1_arb;
  logic        clk, rst_n;
  logic        mode, out_ready;
  logic [1:0]  sel;
  logic [3:0]  in_valid, in_last, in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;

  logic        mode6, out_ready6, out_valid6;
  logic [2:0]  sel6, out_ch6;
  logic [5:0]  in_valid6, in_last6, in_ready6;
  logic [47:0] in_data6;
  logic [7:0]  out_data6;

  mux_nto1_arb #(.N_CH(4), .DATA_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .mode_i(mode), .sel_i(sel),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_last_i(in_last),
    .in_ready_o(in_ready), .out_valid_o(out_valid), .out_data_o(out_data),
    .out_ch_o(out_ch), .out_ready_i(out_ready));

  mux_nto1_arb #(.N_CH(6), .DATA_W(8)) dut6 (
    .clk_i(clk), .rst_ni(rst_n), .mode_i(mode6), .sel_i(sel6),
    .in_valid_i(in_valid6), .in_data_i(in_data6), .in_last_i(in_last6),
    .in_ready_o(in_ready6), .out_valid_o(out_valid6), .out_data_o(out_data6),
    .out_ch_o(out_ch6), .out_ready_i(out_ready6));

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  typedef struct { int ch; logic [7:0] data; } ent_t;
  ent_t sb[$];
  int   n_vec = 0, n_err = 0;
  // reference model state
  logic m_vld;
  int   m_rr;
  logic m_lock;
  int   m_lock_ch;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_grant();
    int c;
    if (!mode) return in_valid[sel] ? int'(sel) : -1;
`ifdef MUX_LAST_LOCK_EN
    if (m_lock) return in_valid[m_lock_ch] ? m_lock_ch : -1;
`endif
    for (int off = 0; off < 4; off++) begin
      c = (m_rr + off) % 4;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  // One clock: check outputs/ready against model, scoreboard, then advance.
  task automatic step();
    int g; logic acc; logic [3:0] er; ent_t e;
    @(negedge clk);
    chk("out_valid", out_valid, m_vld);
    if (m_vld && out_ready) begin
      if (sb.size() == 0) chk("sb_underrun", sb.size(), 1);
      else begin
        e = sb.pop_front();
        chk("out_ch", out_ch, e.ch);
        chk("out_data", out_data, e.data);
      end
    end
    acc = !m_vld || out_ready;
    g   = acc ? model_grant() : -1;
    er  = (g >= 0) ? 4'(1 << g) : 4'b0;
    chk("in_ready", in_ready, er);
    if (g >= 0) begin
      e.ch = g; e.data = in_data[g*8 +: 8];
      sb.push_back(e);
      m_vld = 1'b1;
      if (mode) begin
`ifdef MUX_LAST_LOCK_EN
        if (in_last[g]) begin m_lock = 1'b0; m_rr = (g + 1) % 4; end
        else begin m_lock = 1'b1; m_lock_ch = g; end
`else
        m_rr = (g + 1) % 4;
`endif
      end
    end else if (out_ready) m_vld = 1'b0;
    if (!mode) m_lock = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    m_vld = 1'b0; m_rr = 0; m_lock = 1'b0; m_lock_ch = 0; sb.delete();
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; sel = '0; in_valid = '0; in_last = '0;
    in_data = '0; out_ready = 1'b0;
    mode6 = 1'b0; sel6 = '0; in_valid6 = '0; in_last6 = '0; in_data6 = '0;
    out_ready6 = 1'b1;
    m_vld = 1'b0; m_rr = 0; m_lock = 1'b0; m_lock_ch = 0;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: reset mid-stream with a held 0x5A beat
    in_data[7:0] = 8'h5A; in_valid = 4'b0001; out_ready = 1'b0;
    step();
    in_valid = 4'b0000;
    chk("pre_rst_data", out_data, 8'h5A);
    #2 rst_n = 1'b0; in_valid = 4'b0001; mode = 1'b0; sel = 2'd0;
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 8'h00);
    chk("rst_ch", out_ch, 2'd0);
    chk("rst_ready", in_ready, 4'b0000);
    in_valid = 4'b0000;
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    m_vld = 1'b0; m_rr = 0; m_lock = 1'b0; sb.delete();

    // 2: explicit select sweep
    mode = 1'b0; out_ready = 1'b1; in_valid = 4'b1111;
    in_data = {8'h43, 8'h32, 8'h21, 8'h10};
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      step();
      chk("sel_ch", out_ch, s);
    end
    in_valid = 4'b0000;
    step();

    // 3: round-robin with all channels valid, no bubbles
    do_reset();
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      for (int c = 0; c < 4; c++) in_data[c*8 +: 8] = 8'(c * 16 + i);
      step();
      chk("rr_seq", out_ch, i % 4);
      chk("rr_nobubble", out_valid, 1'b1);
    end
    in_valid = 4'b0000;
    step();

    // 4: wrap from rr_ptr=3 with ch0/ch2 valid
    do_reset();
    mode = 1'b1; out_ready = 1'b1; in_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    in_valid = 4'b0100; step(); chk("rr_setup", out_ch, 2'd2);
    in_valid = 4'b0101; step(); chk("rr_wrap0", out_ch, 2'd0);
    step(); chk("rr_then2", out_ch, 2'd2);
    step(); chk("rr_then0", out_ch, 2'd0);
    in_valid = 4'b0000; step();

    // 5: backpressure, mode/sel wiggle mid-stall, then drain + reload
    do_reset();
    mode = 1'b1; out_ready = 1'b0; in_valid = 4'b0010; in_data[15:8] = 8'h71;
    step();
    in_data[15:8] = 8'h72;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin mode = 1'b0; sel = 2'd2; end
      if (i == 2) mode = 1'b1;
      step();
      chk("stall_data", out_data, 8'h71);
      chk("stall_ch", out_ch, 2'd1);
    end
    out_ready = 1'b1;
    step();
    chk("reload_valid", out_valid, 1'b1);
    chk("reload_data", out_data, 8'h72);
    in_valid = 4'b0000; step();

`ifdef MUX_LAST_LOCK_EN
    // 6: ch1 3-beat packet locks out ch2
    do_reset();
    mode = 1'b1; out_ready = 1'b1; in_valid = 4'b0110;
    for (int b = 0; b < 4; b++) begin
      in_data[15:8] = 8'(8'h90 + b); in_data[23:16] = 8'hE2;
      in_last = (b == 2) ? 4'b0110 : 4'b0100;
      if (b == 3) in_valid = 4'b0100;
      step();
      chk("lock_seq", out_ch, (b < 3) ? 1 : 2);
    end
    in_valid = 4'b0000; in_last = 4'b0000; step();
`endif

    // sel out of range on the 6-channel instance
    in_valid6 = 6'b111111;
    for (int c = 0; c < 6; c++) in_data6[c*8 +: 8] = 8'(8'hA0 + c);
    sel6 = 3'd6;
    @(negedge clk); chk("sel6_rdy", in_ready6, 6'b000000);
    @(posedge clk); #1; chk("sel6_vld", out_valid6, 1'b0);
    sel6 = 3'd5;
    @(negedge clk); chk("sel5_rdy", in_ready6, 6'b100000);
    @(posedge clk); #1;
    chk("sel5_vld", out_valid6, 1'b1);
    chk("sel5_ch", out_ch6, 3'd5);
    chk("sel5_data", out_data6, 8'hA5);
    sel6 = 3'd7;
    @(negedge clk); chk("sel7_rdy", in_ready6, 6'b000000);
    @(posedge clk); #1; chk("sel7_vld", out_valid6, 1'b0);

    // drain and confirm nothing left unmatched
    in_valid = 4'b0000; out_ready = 1'b1;
    step(); step();
    chk("sb_left", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
